// File: rtl/pc_seq_ctrl_if.sv
// Bundle between the hazard/branch/debug side and the PC sequencer.
// The master modport drives requests; the slave modport is the sequencer itself.
interface pc_seq_ctrl_if;
    logic        run_en;
    logic        halt_req;
    logic        step_req;
    logic        hz_stall;
    logic        mem_wait;
    logic        trap_req;
    logic [31:0] trap_target;
    logic        br_req;
    logic [31:0] br_target;
    logic        jal_req;
    logic [31:0] jal_target;

    logic        pc_clkEn;
    logic        pc_stall;
    logic        pc_condEn;
    logic [31:0] pc_next_cond;
    logic        flush_if;
    logic        flush_id;
    logic        halted;
    logic        misalign_err;
    logic [1:0]  redirect_src;

    modport master (
        output run_en, halt_req, step_req, hz_stall, mem_wait,
               trap_req, trap_target, br_req, br_target, jal_req, jal_target,
        input  pc_clkEn, pc_stall, pc_condEn, pc_next_cond,
               flush_if, flush_id, halted, misalign_err, redirect_src
    );

    modport slave (
        input  run_en, halt_req, step_req, hz_stall, mem_wait,
               trap_req, trap_target, br_req, br_target, jal_req, jal_target,
        output pc_clkEn, pc_stall, pc_condEn, pc_next_cond,
               flush_if, flush_id, halted, misalign_err, redirect_src
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// RV32I PC sequencer: boot delay, debug halt/step, redirect arbitration with a
// one-entry pending buffer, and flush pulse generation for IF/ID and ID/EX.
module pc_seq_ctrl #(
    parameter int unsigned BOOT_CYCLES  = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rstB,
    pc_seq_ctrl_if.slave  bus
);

    localparam int unsigned BW = $clog2(BOOT_CYCLES + 1);
    localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [BW-1:0] BOOT_LAST  = BW'(BOOT_CYCLES - 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    // Numeric encoding doubles as priority: larger value wins.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JAL  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_TRAP = 2'd3
    } src_t;

    state_t        state_q, state_d;
    logic [BW-1:0] boot_cnt_q, boot_cnt_d;
    logic          pend_valid_q, pend_valid_d;
    logic [31:0]   pend_target_q, pend_target_d;
    src_t          pend_src_q, pend_src_d;
    src_t          last_src_q, last_src_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;

    logic          clk_en;
    logic          stall;
    logic          adv;
    logic          apply;
    logic          req_any;
    src_t          win_src;
    logic [31:0]   win_target;
    logic          capture;

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            state_q       <= ST_BOOT;
            boot_cnt_q    <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_src_q    <= SRC_NONE;
            last_src_q    <= SRC_NONE;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_src_q    <= pend_src_d;
            last_src_q    <= last_src_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // Sequencing FSM and PC enable/stall generation.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        clk_en     = 1'b0;
        stall      = 1'b0;
        case (state_q)
            ST_BOOT: begin
                boot_cnt_d = boot_cnt_q + BW'(1);
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                clk_en = bus.run_en;
                stall  = bus.hz_stall | bus.mem_wait;
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!bus.halt_req) begin
                    state_d = ST_RUN;
                end else if (bus.step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                // run_en still gates the step; the step completes only on a real advance.
                clk_en = bus.run_en;
                stall  = bus.hz_stall | bus.mem_wait;
                if (clk_en && !stall) begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign adv   = clk_en & ~stall;
    assign apply = pend_valid_q & adv;

    always_comb begin
        req_any    = 1'b1;
        win_src    = SRC_NONE;
        win_target = '0;
        if (bus.trap_req) begin
            win_src    = SRC_TRAP;
            win_target = bus.trap_target;
        end else if (bus.br_req) begin
            win_src    = SRC_BR;
            win_target = bus.br_target;
        end else if (bus.jal_req) begin
            win_src    = SRC_JAL;
            win_target = bus.jal_target;
        end else begin
            req_any = 1'b0;
        end
    end

    // An apply frees the slot, so a same-cycle request lands regardless of priority.
    assign capture = (state_q != ST_BOOT) & req_any &
                     (apply | ~pend_valid_q | (win_src >= pend_src_q));

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_src_d    = pend_src_q;
        last_src_d    = last_src_q;
        flush_cnt_d   = flush_cnt_q;

        if (apply) begin
            pend_valid_d = 1'b0;
            last_src_d   = pend_src_q;
            flush_cnt_d  = FLUSH_LOAD;
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d  = flush_cnt_q - FW'(1);
        end

        if (capture) begin
            pend_valid_d  = 1'b1;
            pend_target_d = win_target;
            pend_src_d    = win_src;
        end
    end

    assign bus.pc_clkEn     = clk_en;
    assign bus.pc_stall     = stall;
    assign bus.pc_condEn    = apply;
    assign bus.pc_next_cond = {pend_target_q[31:2], 2'b00};
    assign bus.flush_if     = (flush_cnt_q != '0);
    assign bus.flush_id     = (flush_cnt_q != '0);
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.misalign_err = apply & (|pend_target_q[1:0]);
    assign bus.redirect_src = apply ? pend_src_q : last_src_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl with BOOT_CYCLES=4, FLUSH_CYCLES=2.
module tb_pc_seq_ctrl;

    logic clk;
    logic rstB;
    int   checks;
    int   failures;

    pc_seq_ctrl_if bus ();

    pc_seq_ctrl #(
        .BOOT_CYCLES  (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk  (clk),
        .rstB (rstB),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clkEn"},  32'(bus.pc_clkEn),     32'h0);
        check({tag, "_stall"},  32'(bus.pc_stall),     32'h0);
        check({tag, "_condEn"}, 32'(bus.pc_condEn),    32'h0);
        check({tag, "_next"},   bus.pc_next_cond,      32'h0);
        check({tag, "_fif"},    32'(bus.flush_if),     32'h0);
        check({tag, "_fid"},    32'(bus.flush_id),     32'h0);
        check({tag, "_halted"}, 32'(bus.halted),       32'h0);
        check({tag, "_mis"},    32'(bus.misalign_err), 32'h0);
        check({tag, "_src"},    32'(bus.redirect_src), 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstB             = 1'b0;
        bus.run_en       = 1'b1;
        bus.halt_req     = 1'b0;
        bus.step_req     = 1'b0;
        bus.hz_stall     = 1'b0;
        bus.mem_wait     = 1'b0;
        bus.trap_req     = 1'b0;
        bus.trap_target  = '0;
        bus.br_req       = 1'b0;
        bus.br_target    = '0;
        bus.jal_req      = 1'b0;
        bus.jal_target   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");

        // Boot: 4 cycles of clkEn=0; a request during boot must be ignored
        rstB = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.br_req    = (i == 2);
            bus.br_target = 32'h500;
            settle();
            check("boot_clkEn", 32'(bus.pc_clkEn), 32'h0);
            check("boot_flush", 32'(bus.flush_if), 32'h0);
            tick();
        end
        bus.br_req = 1'b0;
        settle();
        check("run_clkEn", 32'(bus.pc_clkEn), 32'h1);
        check("run_condEn_noboot", 32'(bus.pc_condEn), 32'h0);
        check("run_src0", 32'(bus.redirect_src), 32'h0);
        check("run_halted", 32'(bus.halted), 32'h0);

        // Simple branch redirect with flush window
        bus.br_req    = 1'b1;
        bus.br_target = 32'h100;
        settle();
        check("br_req_cycle_condEn", 32'(bus.pc_condEn), 32'h0);
        tick();
        bus.br_req = 1'b0;
        settle();
        check("br_condEn", 32'(bus.pc_condEn), 32'h1);
        check("br_next", bus.pc_next_cond, 32'h100);
        check("br_src", 32'(bus.redirect_src), 32'h2);
        check("br_flush_apply", 32'(bus.flush_if), 32'h0);
        check("br_mis", 32'(bus.misalign_err), 32'h0);
        tick();
        check("br_fif1", 32'(bus.flush_if), 32'h1);
        check("br_fid1", 32'(bus.flush_id), 32'h1);
        check("br_condEn_after", 32'(bus.pc_condEn), 32'h0);
        tick();
        check("br_fif2", 32'(bus.flush_if), 32'h1);
        check("br_fid2", 32'(bus.flush_id), 32'h1);
        tick();
        check("br_fif3", 32'(bus.flush_if), 32'h0);
        check("br_fid3", 32'(bus.flush_id), 32'h0);
        check("br_src_hold", 32'(bus.redirect_src), 32'h2);

        // Simultaneous trap/br/jal: trap wins, losers dropped
        bus.trap_req    = 1'b1;
        bus.trap_target = 32'h80;
        bus.br_req      = 1'b1;
        bus.br_target   = 32'h200;
        bus.jal_req     = 1'b1;
        bus.jal_target  = 32'h300;
        settle();
        check("arb_req_condEn", 32'(bus.pc_condEn), 32'h0);
        tick();
        bus.trap_req = 1'b0;
        bus.br_req   = 1'b0;
        bus.jal_req  = 1'b0;
        settle();
        check("arb_condEn", 32'(bus.pc_condEn), 32'h1);
        check("arb_next", bus.pc_next_cond, 32'h80);
        check("arb_src", 32'(bus.redirect_src), 32'h3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arb_no_reapply", 32'(bus.pc_condEn), 32'h0);
        end
        check("arb_flush_done", 32'(bus.flush_if), 32'h0);

        // JAL held during mem_wait, overwritten by higher-priority branch
        bus.mem_wait   = 1'b1;
        bus.jal_req    = 1'b1;
        bus.jal_target = 32'h40;
        settle();
        check("mw_stall", 32'(bus.pc_stall), 32'h1);
        check("mw_condEn0", 32'(bus.pc_condEn), 32'h0);
        tick();
        bus.jal_req = 1'b0;
        settle();
        check("mw_condEn1", 32'(bus.pc_condEn), 32'h0);
        check("mw_next_jal", bus.pc_next_cond, 32'h40);
        tick();
        check("mw_condEn2", 32'(bus.pc_condEn), 32'h0);
        tick();
        bus.br_req    = 1'b1;
        bus.br_target = 32'h60;
        settle();
        check("mw_condEn3", 32'(bus.pc_condEn), 32'h0);
        tick();
        bus.br_req = 1'b0;
        settle();
        check("mw_condEn4", 32'(bus.pc_condEn), 32'h0);
        check("mw_next_br", bus.pc_next_cond, 32'h60);
        check("mw_src_old", 32'(bus.redirect_src), 32'h3);
        tick();
        bus.mem_wait = 1'b0;
        settle();
        check("mw_apply_condEn", 32'(bus.pc_condEn), 32'h1);
        check("mw_apply_next", bus.pc_next_cond, 32'h60);
        check("mw_apply_src", 32'(bus.redirect_src), 32'h2);
        tick();
        check("mw_after_condEn", 32'(bus.pc_condEn), 32'h0);
        repeat (3) tick();

        // Debug halt and single step
        bus.halt_req = 1'b1;
        settle();
        check("hlt_req_clkEn", 32'(bus.pc_clkEn), 32'h1);
        check("hlt_req_halted", 32'(bus.halted), 32'h0);
        tick();
        check("hlt_halted", 32'(bus.halted), 32'h1);
        check("hlt_clkEn", 32'(bus.pc_clkEn), 32'h0);
        bus.step_req = 1'b1;
        settle();
        check("hlt_step_halted", 32'(bus.halted), 32'h1);
        tick();
        bus.step_req = 1'b0;
        settle();
        check("step_clkEn", 32'(bus.pc_clkEn), 32'h1);
        check("step_halted", 32'(bus.halted), 32'h0);
        check("step_stall", 32'(bus.pc_stall), 32'h0);
        tick();
        check("step_back_halted", 32'(bus.halted), 32'h1);
        check("step_back_clkEn", 32'(bus.pc_clkEn), 32'h0);
        bus.halt_req = 1'b0;
        tick();
        check("resume_halted", 32'(bus.halted), 32'h0);
        check("resume_clkEn", 32'(bus.pc_clkEn), 32'h1);

        // Misaligned target
        bus.br_req    = 1'b1;
        bus.br_target = 32'h102;
        tick();
        bus.br_req = 1'b0;
        settle();
        check("mis_condEn", 32'(bus.pc_condEn), 32'h1);
        check("mis_next", bus.pc_next_cond, 32'h100);
        check("mis_err", 32'(bus.misalign_err), 32'h1);
        tick();
        check("mis_err_clear", 32'(bus.misalign_err), 32'h0);
        repeat (3) tick();

        // Reset with a pending redirect
        bus.mem_wait   = 1'b1;
        bus.jal_req    = 1'b1;
        bus.jal_target = 32'h44;
        tick();
        bus.jal_req = 1'b0;
        settle();
        check("rp_pending_condEn", 32'(bus.pc_condEn), 32'h0);
        check("rp_pending_next", bus.pc_next_cond, 32'h44);
        rstB = 1'b0;
        settle();
        check_all_zero("rp_async");
        repeat (2) tick();
        rstB         = 1'b1;
        bus.mem_wait = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rp_boot_clkEn", 32'(bus.pc_clkEn), 32'h0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            settle();
            check("rp_run_clkEn", 32'(bus.pc_clkEn), 32'h1);
            check("rp_no_apply", 32'(bus.pc_condEn), 32'h0);
            check("rp_src", 32'(bus.redirect_src), 32'h0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
